// File: rtl/uart_pattern_matcher.sv
// Purpose : sliding-window matcher for a programmable 1..MAX_LEN byte sequence
//           on the UART sampler byte stream. Each hit counts once, so
//           overlapping occurrences all count.
// Latency : match pulses one cycle after the data_valid of the completing byte;
//           match_count updates on the same edge.
// Backpressure: none. A byte is accepted on every data_valid cycle, back-to-back
//           included. A pattern write in the same cycle discards that byte.
//
// Ports:
//   sys_clk      in   clock, rising edge
//   reset        in   asynchronous active-high reset
//   data_in      in   received byte, qualified by data_valid
//   data_valid   in   one-cycle byte strobe
//   pat_wr_en    in   pattern byte write strobe (also flushes the window)
//   pat_wr_addr  in   pattern index, 0 = first byte on the line
//   pat_wr_data  in   pattern byte
//   pat_len      in   active pattern length; 0 or >MAX_LEN disables matching
//   clear        in   synchronous clear of match_count
//   match        out  one-cycle pulse per detected occurrence
//   match_count  out  saturating hit counter
module uart_pattern_matcher #(
  parameter int MAX_LEN = 4,
  parameter int LEN_W   = 3,
  parameter int ADDR_W  = 2,
  parameter int CNT_W   = 16
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic [7:0]        data_in,
  input  logic              data_valid,
  input  logic              pat_wr_en,
  input  logic [ADDR_W-1:0] pat_wr_addr,
  input  logic [7:0]        pat_wr_data,
  input  logic [LEN_W-1:0]  pat_len,
  input  logic              clear,
  output logic              match,
  output logic [CNT_W-1:0]  match_count
);

  logic [7:0]       pat  [MAX_LEN];
  logic [7:0]       hist [MAX_LEN];   // hist[0] is the newest byte
  logic [LEN_W-1:0] fill;

  logic       accept;
  logic       hit;
  logic [7:0] win [MAX_LEN];          // win[0] is the incoming byte, then the pre-shift history
  int         plen;

  always_comb begin
    accept = data_valid & ~pat_wr_en;
    plen   = int'(pat_len);
    win[0] = data_in;
    for (int i = 1; i < MAX_LEN; i++) begin
      win[i] = hist[i-1];
    end

    hit = accept && (plen >= 1) && (plen <= MAX_LEN) && ((int'(fill) + 1) >= plen);
    // The newest byte lines up with the last pattern byte. Window slot i is
    // compared against pattern index plen-1-i. The inner loop acts as the
    // variable-index mux onto pat[].
    for (int i = 0; i < MAX_LEN; i++) begin
      for (int j = 0; j < MAX_LEN; j++) begin
        if ((i < plen) && (j == plen - 1 - i) && (win[i] != pat[j])) begin
          hit = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      match       <= 1'b0;
      match_count <= '0;
      fill        <= '0;
      for (int k = 0; k < MAX_LEN; k++) begin
        pat[k]  <= 8'h00;
        hist[k] <= 8'h00;
      end
    end else begin
      match <= hit;

      if (pat_wr_en) begin
        // Addresses with no matching slot fall through, so they are ignored.
        for (int k = 0; k < MAX_LEN; k++) begin
          if (pat_wr_addr == ADDR_W'(k)) begin
            pat[k] <= pat_wr_data;
          end
        end
        fill <= '0;
      end else if (data_valid) begin
        hist[0] <= data_in;
        for (int k = 1; k < MAX_LEN; k++) begin
          hist[k] <= hist[k-1];
        end
        if (int'(fill) < MAX_LEN) begin
          fill <= fill + LEN_W'(1);
        end
      end

      // A clear that coincides with a hit still counts that hit.
      if (clear) begin
        match_count <= hit ? CNT_W'(1) : '0;
      end else if (hit && (match_count != '1)) begin
        match_count <= match_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_pattern_matcher.sv
module tb_uart_pattern_matcher;
  localparam int MAX_LEN = 4;
  localparam int LEN_W   = 3;
  localparam int ADDR_W  = 3;
  localparam int CNT_W   = 2;

  logic              sys_clk;
  logic              reset;
  logic [7:0]        data_in;
  logic              data_valid;
  logic              pat_wr_en;
  logic [ADDR_W-1:0] pat_wr_addr;
  logic [7:0]        pat_wr_data;
  logic [LEN_W-1:0]  pat_len;
  logic              clear;
  logic              match;
  logic [CNT_W-1:0]  match_count;

  uart_pattern_matcher #(
    .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .sys_clk(sys_clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .pat_wr_en(pat_wr_en), .pat_wr_addr(pat_wr_addr), .pat_wr_data(pat_wr_data),
    .pat_len(pat_len), .clear(clear), .match(match), .match_count(match_count)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    int               cyc;
    logic             m;
    logic [CNT_W-1:0] cnt;
    string            nm;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  // Monitor: compares outputs for every cycle that has an expectation and
  // flags any match pulse on a cycle that has none.
  always @(negedge sys_clk) begin : mon
    exp_t e;
    if (!reset) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL %s: expected slot at cycle %0d was never sampled", e.nm, e.cyc);
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        vectors++;
        if (match !== e.m || match_count !== e.cnt) begin
          miscompares++;
          $display("FAIL %s: match=%0b count=%0d, required match=%0b count=%0d",
                   e.nm, match, match_count, e.m, e.cnt);
        end
      end else if (match !== 1'b0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_match: match=%0b at cycle %0d, required 0", match, cyc);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs (called just after a negedge) and queue the
  // output expected on the following cycle.
  task automatic drive(input logic v, input logic [7:0] d, input logic wr,
                       input logic [ADDR_W-1:0] a, input logic [7:0] wd, input logic clr,
                       input logic em, input logic [CNT_W-1:0] ec, input string nm);
    exp_t e;
    data_valid  = v;
    data_in     = d;
    pat_wr_en   = wr;
    pat_wr_addr = a;
    pat_wr_data = wd;
    clear       = clr;
    e.cyc = cyc + 1;
    e.m   = em;
    e.cnt = ec;
    e.nm  = nm;
    q.push_back(e);
    @(negedge sys_clk);
    data_valid = 1'b0;
    pat_wr_en  = 1'b0;
    clear      = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic em, input logic [CNT_W-1:0] ec,
                      input string nm);
    drive(1'b1, d, 1'b0, '0, 8'h00, 1'b0, em, ec, nm);
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [7:0] wd,
                    input logic [CNT_W-1:0] ec, input string nm);
    drive(1'b0, 8'h00, 1'b1, a, wd, 1'b0, 1'b0, ec, nm);
  endtask

  task automatic clr(input string nm);
    drive(1'b0, 8'h00, 1'b0, '0, 8'h00, 1'b1, 1'b0, '0, nm);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  initial begin
    reset = 1'b1; data_in = 8'h00; data_valid = 1'b0; pat_wr_en = 1'b0;
    pat_wr_addr = '0; pat_wr_data = 8'h00; pat_len = 3'd2; clear = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("reset_match", int'(match), 0);
    chk("reset_count", int'(match_count), 0);
    reset = 1'b0;
    idle(1);

    // Fill guard on the all-zero reset pattern, then flush by a write
    send(8'h00, 1'b0, 2'd0, "zero_fill_guard");
    send(8'h00, 1'b1, 2'd1, "zero_match");
    drive(1'b1, 8'h00, 1'b1, 3'd0, 8'h00, 1'b0, 1'b0, 2'd1, "write_discards_byte");
    send(8'h00, 1'b0, 2'd1, "flushed_window");
    send(8'h00, 1'b1, 2'd2, "refilled_match");
    clr("clear_1");

    // Basic 4-byte match with gaps between strobes
    wr(3'd0, 8'h41, 2'd0, "wr0");
    wr(3'd1, 8'h42, 2'd0, "wr1");
    wr(3'd2, 8'h43, 2'd0, "wr2");
    wr(3'd3, 8'h44, 2'd0, "wr3");
    pat_len = 3'd4;
    send(8'h41, 1'b0, 2'd0, "basic_b0"); idle(2);
    send(8'h42, 1'b0, 2'd0, "basic_b1"); idle(1);
    send(8'h43, 1'b0, 2'd0, "basic_b2"); idle(3);
    send(8'h44, 1'b1, 2'd1, "basic_hit");
    idle(2);
    clr("clear_2");

    // Overlap, back-to-back, saturation, clear together with a hit
    wr(3'd0, 8'h55, 2'd0, "wr55_0");
    wr(3'd1, 8'h55, 2'd0, "wr55_1");
    pat_len = 3'd2;
    send(8'h55, 1'b0, 2'd0, "ovl_first");
    send(8'h55, 1'b1, 2'd1, "ovl_hit1");
    send(8'h55, 1'b1, 2'd2, "ovl_hit2");
    send(8'h55, 1'b1, 2'd3, "sat_hit3");
    send(8'h55, 1'b1, 2'd3, "sat_hit4");
    send(8'h55, 1'b1, 2'd3, "sat_hit5");
    drive(1'b1, 8'h55, 1'b0, '0, 8'h00, 1'b1, 1'b1, 2'd1, "clear_with_hit");
    idle(1);

    // Partial-prefix restart and a near miss
    wr(3'd0, 8'h41, 2'd1, "wrp0");
    wr(3'd1, 8'h42, 2'd1, "wrp1");
    wr(3'd2, 8'h43, 2'd1, "wrp2");
    pat_len = 3'd3;
    send(8'h41, 1'b0, 2'd1, "pre_41a");
    send(8'h41, 1'b0, 2'd1, "pre_41b");
    send(8'h42, 1'b0, 2'd1, "pre_42");
    send(8'h43, 1'b1, 2'd2, "pre_hit");
    send(8'h41, 1'b0, 2'd2, "miss_41");
    send(8'h42, 1'b0, 2'd2, "miss_42");
    send(8'h44, 1'b0, 2'd2, "miss_44");
    send(8'h43, 1'b0, 2'd2, "miss_43");

    // Disabled lengths; a length change keeps the window
    pat_len = 3'd0;
    send(8'h41, 1'b0, 2'd2, "len0_41");
    send(8'h42, 1'b0, 2'd2, "len0_42");
    send(8'h43, 1'b0, 2'd2, "len0_43");
    pat_len = 3'd7;
    send(8'h41, 1'b0, 2'd2, "len7_41");
    send(8'h42, 1'b0, 2'd2, "len7_42");
    pat_len = 3'd3;
    send(8'h43, 1'b1, 2'd3, "len_change_hit");
    clr("clear_3");

    // An out-of-range write leaves the pattern untouched
    wr(3'd4, 8'h00, 2'd0, "wr_addr4_ignored");
    send(8'h41, 1'b0, 2'd0, "oor_41");
    send(8'h42, 1'b0, 2'd0, "oor_42");
    send(8'h43, 1'b1, 2'd1, "oor_hit");

    // Reset mid-pattern
    pat_len = 3'd4;
    send(8'h41, 1'b0, 2'd1, "rst_41");
    send(8'h42, 1'b0, 2'd1, "rst_42");
    send(8'h43, 1'b0, 2'd1, "rst_43");
    idle(1);
    reset = 1'b1;
    #1;
    chk("async_reset_count", int'(match_count), 0);
    chk("async_reset_match", int'(match), 0);
    @(negedge sys_clk);
    reset = 1'b0;
    chk("post_reset_count", int'(match_count), 0);
    wr(3'd0, 8'h41, 2'd0, "rl0");
    wr(3'd1, 8'h42, 2'd0, "rl1");
    wr(3'd2, 8'h43, 2'd0, "rl2");
    wr(3'd3, 8'h44, 2'd0, "rl3");
    send(8'h44, 1'b0, 2'd0, "post_reset_44");
    send(8'h41, 1'b0, 2'd0, "fresh_41");
    send(8'h42, 1'b0, 2'd0, "fresh_42");
    send(8'h43, 1'b0, 2'd0, "fresh_43");
    send(8'h44, 1'b1, 2'd1, "fresh_hit");

    idle(3);
    chk("scoreboard_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
